// File: rtl/vram_arbiter_if.sv
// Bus bundle for vram_arbiter: display fetch port, CPU port and VRAM pins.
// The arbiter uses the slave modport; display, CPU and VRAM sit on the master side.
interface vram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int MASK_W = 4
);
  logic              disp_req_i;
  logic [ADDR_W-1:0] disp_addr_i;
  logic              disp_gnt_o;
  logic              disp_rvalid_o;
  logic [DATA_W-1:0] disp_rdata_o;
  logic              cpu_req_i;
  logic              cpu_wr_i;
  logic [MASK_W-1:0] cpu_mask_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [DATA_W-1:0] cpu_wdata_i;
  logic              cpu_ack_o;
  logic [DATA_W-1:0] cpu_rdata_o;
  logic              vram_sel_o;
  logic              vram_wr_o;
  logic [MASK_W-1:0] vram_mask_o;
  logic [ADDR_W-1:0] vram_addr_o;
  logic [DATA_W-1:0] vram_data_out_o;
  logic [DATA_W-1:0] vram_data_in_i;

  modport slave (
    input  disp_req_i, disp_addr_i, cpu_req_i, cpu_wr_i, cpu_mask_i, cpu_addr_i,
           cpu_wdata_i, vram_data_in_i,
    output disp_gnt_o, disp_rvalid_o, disp_rdata_o, cpu_ack_o, cpu_rdata_o,
           vram_sel_o, vram_wr_o, vram_mask_o, vram_addr_o, vram_data_out_o
  );

  modport master (
    output disp_req_i, disp_addr_i, cpu_req_i, cpu_wr_i, cpu_mask_i, cpu_addr_i,
           cpu_wdata_i, vram_data_in_i,
    input  disp_gnt_o, disp_rvalid_o, disp_rdata_o, cpu_ack_o, cpu_rdata_o,
           vram_sel_o, vram_wr_o, vram_mask_o, vram_addr_o, vram_data_out_o
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port text VRAM arbiter: display fetch has priority, CPU is guaranteed a slot after
// CPU_MAX_WAIT display grants. Optional statistics counters under `VRAM_ARB_STATS_EN`.
module vram_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int MASK_W       = 4,
  parameter int RD_LAT       = 1,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         reset_ni,
`ifdef VRAM_ARB_STATS_EN
  input  logic         stat_clear_i,
  output logic [15:0]  stat_disp_defer_o,
  output logic [15:0]  stat_cpu_wait_o,
`endif
  vram_arbiter_if.slave bus
);
  localparam int SW = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(CPU_MAX_WAIT);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);

  typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_DISP = 2'd1, TAG_CPU = 2'd2} tag_e;
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RD_WAIT = 1'b1} cpu_st_e;

  cpu_st_e           r_state;
  cpu_st_e           w_state_nxt;
  logic [SW-1:0]     r_starve;
  logic [SW-1:0]     w_starve_nxt;
  tag_e              r_tag [RD_LAT+1];
  tag_e              w_issue_tag;
  tag_e              w_ret_tag;
  logic              w_cpu_elig;
  logic              w_cpu_gnt;
  logic              w_disp_gnt;
  logic              w_cpu_ack_nxt;
  logic              r_cpu_ack;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_disp_rvalid;
  logic [DATA_W-1:0] r_disp_rdata;
  logic              r_sel;
  logic              r_wr;
  logic [MASK_W-1:0] r_mask;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  // The ack cycle blocks re-grant so a CPU still holding req is served no earlier than t+2.
  assign w_cpu_elig = bus.cpu_req_i & (r_state == ST_IDLE) & ~r_cpu_ack;
  assign w_cpu_gnt  = reset_ni & w_cpu_elig & (~bus.disp_req_i | (r_starve == STARVE_MAX));
  assign w_disp_gnt = reset_ni & bus.disp_req_i & ~w_cpu_gnt;
  assign w_ret_tag  = r_tag[RD_LAT];

  assign bus.disp_gnt_o      = w_disp_gnt;
  assign bus.disp_rvalid_o   = r_disp_rvalid;
  assign bus.disp_rdata_o    = r_disp_rdata;
  assign bus.cpu_ack_o       = r_cpu_ack;
  assign bus.cpu_rdata_o     = r_cpu_rdata;
  assign bus.vram_sel_o      = r_sel;
  assign bus.vram_wr_o       = r_wr;
  assign bus.vram_mask_o     = r_mask;
  assign bus.vram_addr_o     = r_addr;
  assign bus.vram_data_out_o = r_wdata;

  // Starvation counter next value.
  always_comb begin
    w_starve_nxt = r_starve;
    if (!bus.cpu_req_i || w_cpu_gnt) begin
      w_starve_nxt = '0;
    end else if (w_disp_gnt && w_cpu_elig && (r_starve != STARVE_MAX)) begin
      w_starve_nxt = r_starve + STARVE_ONE;
    end else begin
      w_starve_nxt = r_starve;
    end
  end

  // Owner tag for the access issued this cycle; writes return nothing.
  always_comb begin
    w_issue_tag = TAG_NONE;
    if (w_cpu_gnt && !bus.cpu_wr_i) begin
      w_issue_tag = TAG_CPU;
    end else if (w_disp_gnt) begin
      w_issue_tag = TAG_DISP;
    end else begin
      w_issue_tag = TAG_NONE;
    end
  end

  // CPU FSM next state and ack.
  always_comb begin
    w_state_nxt   = r_state;
    w_cpu_ack_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cpu_gnt && !bus.cpu_wr_i) begin
          w_state_nxt = ST_RD_WAIT;
        end else begin
          w_state_nxt   = ST_IDLE;
          w_cpu_ack_nxt = w_cpu_gnt & bus.cpu_wr_i;
        end
      end
      ST_RD_WAIT: begin
        if (w_ret_tag == TAG_CPU) begin
          w_state_nxt   = ST_IDLE;
          w_cpu_ack_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_RD_WAIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state, starvation counter and CPU ack registers.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state   <= ST_IDLE;
      r_starve  <= '0;
      r_cpu_ack <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_starve  <= w_starve_nxt;
      r_cpu_ack <= w_cpu_ack_nxt;
    end
  end

  // Registered VRAM bus; address and data hold when idle.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_sel   <= 1'b0;
      r_wr    <= 1'b0;
      r_mask  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_sel <= w_cpu_gnt | w_disp_gnt;
      r_wr  <= w_cpu_gnt & bus.cpu_wr_i;
      if (w_cpu_gnt) begin
        r_addr  <= bus.cpu_addr_i;
        r_mask  <= bus.cpu_mask_i;
        r_wdata <= bus.cpu_wdata_i;
      end else if (w_disp_gnt) begin
        r_addr <= bus.disp_addr_i;
      end
    end
  end

  // Owner tag pipe: stage RD_LAT lines up with the cycle the read word is on vram_data_in_i.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int k = 0; k <= RD_LAT; k++) r_tag[k] <= TAG_NONE;
    end else begin
      r_tag[0] <= w_issue_tag;
      for (int k = 1; k <= RD_LAT; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  // Steer returning read data to its owner.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_disp_rvalid <= 1'b0;
      r_disp_rdata  <= '0;
      r_cpu_rdata   <= '0;
    end else begin
      r_disp_rvalid <= (w_ret_tag == TAG_DISP);
      if (w_ret_tag == TAG_DISP) begin
        r_disp_rdata <= bus.vram_data_in_i;
      end
      if ((r_state == ST_RD_WAIT) && (w_ret_tag == TAG_CPU)) begin
        r_cpu_rdata <= bus.vram_data_in_i;
      end
    end
  end

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] r_stat_defer;
  logic [15:0] r_stat_wait;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic inc);
    if (inc && (v != 16'hFFFF)) sat_inc16 = v + 16'd1;
    else sat_inc16 = v;
  endfunction

  assign stat_disp_defer_o = r_stat_defer;
  assign stat_cpu_wait_o   = r_stat_wait;

  // Saturating stall counters; clear beats increment.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_stat_defer <= 16'd0;
      r_stat_wait  <= 16'd0;
    end else if (stat_clear_i) begin
      r_stat_defer <= 16'd0;
      r_stat_wait  <= 16'd0;
    end else begin
      r_stat_defer <= sat_inc16(r_stat_defer, bus.disp_req_i & ~w_disp_gnt);
      r_stat_wait  <= sat_inc16(r_stat_wait, w_cpu_elig & ~w_cpu_gnt);
    end
  end
`else
  // Statistics build option off: no counter hardware.
`endif
endmodule
